// File: rtl/mux41_sel_scan.sv
// Select sequencer for a 4:1 mux. It steps through the channels enabled in
// `mask` in ascending order and holds each one for dwell+1 cycles. It pulses
// ch_start on the first cycle of each hold and frame_done on the last hold
// cycle of the highest enabled channel. All outputs are registered.
module mux41_sel_scan #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               valid,
    output logic               ch_start,
    output logic               frame_done
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               ch_start_q, ch_start_d;
    logic               frame_done_q, frame_done_d;
    logic               load;
    logic [3:0]         above;
    logic [1:0]         next_ch;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    // Channels strictly above channel c.
    function automatic logic [3:0] above_mask(input logic [1:0] c);
        unique case (c)
            2'd0:    above_mask = 4'b1110;
            2'd1:    above_mask = 4'b1100;
            2'd2:    above_mask = 4'b1000;
            default: above_mask = 4'b0000;
        endcase
    endfunction

    // Next enabled channel above the current one, wrapping to the lowest.
    always_comb begin
        above   = mask & above_mask(ch_q);
        next_ch = (above != 4'b0000) ? lowest_set(above) : lowest_set(mask);
    end

    // State register, channel and dwell counter, registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_q         <= 2'd0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            ch_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            ch_start_q   <= ch_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: start, count down the hold, advance, or stop.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ch_d  = 2'd0;
                cnt_d = '0;
                if (en && mask != 4'b0000) begin
                    state_d = StScan;
                    ch_d    = lowest_set(mask);
                    cnt_d   = dwell;
                    load    = 1'b1;
                end
            end
            StScan: begin
                if (!en) begin
                    state_d = StIdle;
                    ch_d    = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (mask == 4'b0000) begin
                    state_d = StIdle;
                    ch_d    = 2'd0;
                    cnt_d   = '0;
                end else begin
                    ch_d  = next_ch;
                    cnt_d = dwell;
                    load  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ch_d    = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode for the cycle after this edge.
    always_comb begin
        valid_d      = (state_d == StScan);
        ch_start_d   = load;
        frame_done_d = valid_d && (cnt_d == '0) && ((mask & above_mask(ch_d)) == 4'b0000);
    end

    assign s0         = ch_q[0];
    assign s1         = ch_q[1];
    assign valid      = valid_q;
    assign ch_start   = ch_start_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux41_sel_scan.sv
// Self-checking bench for mux41_sel_scan: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_mux41_sel_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [7:0] dwell = 8'd0;
    logic       s0, s1, valid, ch_start, frame_done;

    int checks = 0;
    int errors = 0;

    mux41_sel_scan #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mask      (mask),
        .dwell     (dwell),
        .s0        (s0),
        .s1        (s1),
        .valid     (valid),
        .ch_start  (ch_start),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: channel, remaining hold cycles, pulse flags.
    bit m_scan;
    int m_ch;
    int m_rem;
    bit m_cs;
    bit m_fd;

    function automatic int first_set_from(input logic [3:0] m, input int lo);
        for (int i = lo; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_scan = 0; m_ch = 0; m_rem = 0; m_cs = 0; m_fd = 0;
    endfunction

    function automatic void model_edge(input bit e, input logic [3:0] m, input int d);
        int nxt;
        m_cs = 0;
        if (!m_scan) begin
            if (e && m != 0) begin
                m_scan = 1; m_ch = first_set_from(m, 0); m_rem = d; m_cs = 1;
            end
        end else if (!e) begin
            m_scan = 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (m == 0) begin
            m_scan = 0;
        end else begin
            nxt = first_set_from(m, m_ch + 1);
            m_ch = (nxt < 0) ? first_set_from(m, 0) : nxt;
            m_rem = d;
            m_cs = 1;
        end
        if (!m_scan) begin
            m_ch = 0; m_rem = 0;
        end
        m_fd = m_scan && m_rem == 0 && first_set_from(m, m_ch + 1) < 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("sel", int'({s1, s0}), m_scan ? m_ch : 0);
        check("valid", int'(valid), int'(m_scan));
        check("ch_start", int'(ch_start), int'(m_cs));
        check("frame_done", int'(frame_done), int'(m_fd));
    endtask

    // One clock: drive inputs, let the edge happen, compare 1ns later.
    task automatic step(input bit e, input logic [3:0] m, input logic [7:0] d);
        en = e; mask = m; dwell = d;
        @(posedge clk);
        model_edge(e, m, int'(d));
        #1;
        check_model();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_sel", int'({s1, s0}), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_cs", int'(ch_start), 0);
        check("rst_fd", int'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         en;
        logic [3:0] mask;
        logic [7:0] dwell;
        int         sel;
        bit         vld;
        bit         cs;
        bit         fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, input logic [3:0] m, input logic [7:0] d,
                       input int sel, input bit v, input bit cs, input bit fd);
        vec_t t;
        t.en = e; t.mask = m; t.dwell = d; t.sel = sel; t.vld = v; t.cs = cs; t.fd = fd;
        vecs.push_back(t);
    endtask

    initial begin
        int last_cs;
        int cyc;
        logic [3:0] rm;

        // Full scan, mask 1111 dwell 1.
        add(1, 4'hF, 8'd1, 0, 1, 1, 0);
        add(1, 4'hF, 8'd1, 0, 1, 0, 0);
        add(1, 4'hF, 8'd1, 1, 1, 1, 0);
        add(1, 4'hF, 8'd1, 1, 1, 0, 0);
        add(1, 4'hF, 8'd1, 2, 1, 1, 0);
        add(1, 4'hF, 8'd1, 2, 1, 0, 0);
        add(1, 4'hF, 8'd1, 3, 1, 1, 0);
        add(1, 4'hF, 8'd1, 3, 1, 0, 1);
        add(1, 4'hF, 8'd1, 0, 1, 1, 0);
        add(0, 4'hF, 8'd1, 0, 0, 0, 0);
        // Sparse mask 1010 dwell 0.
        add(1, 4'hA, 8'd0, 1, 1, 1, 0);
        add(1, 4'hA, 8'd0, 3, 1, 1, 1);
        add(1, 4'hA, 8'd0, 1, 1, 1, 0);
        add(1, 4'hA, 8'd0, 3, 1, 1, 1);
        add(0, 4'hA, 8'd0, 0, 0, 0, 0);

        // Reset held with en=1, released mid-cycle.
        model_reset();
        en = 1'b1; mask = 4'hF; dwell = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("inrst_valid", int'(valid), 0);
            check("inrst_cs", int'(ch_start), 0);
            check("inrst_sel", int'({s1, s0}), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'hF, 8'd1);
        check("start_valid", int'(valid), 1);
        check("start_cs", int'(ch_start), 1);
        step(1, 4'hF, 8'd1);
        step(1, 4'hF, 8'd1);
        async_reset();

        // Directed vector table.
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].mask, vecs[i].dwell);
            check("vec_sel", int'({s1, s0}), vecs[i].sel);
            check("vec_valid", int'(valid), int'(vecs[i].vld));
            check("vec_cs", int'(ch_start), int'(vecs[i].cs));
            check("vec_fd", int'(frame_done), int'(vecs[i].fd));
        end

        // Mask shrinks to 0001 during the ch1 hold.
        for (int i = 0; i < 5; i++) step(1, 4'hF, 8'd3);
        check("mh_ch1", int'({s1, s0}), 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'h1, 8'd3);
            check("mh_hold1", int'({s1, s0}), 1);
        end
        step(1, 4'h1, 8'd3);
        check("mh_wrap", int'({s1, s0}), 0);
        check("mh_wrap_cs", int'(ch_start), 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 4'h1, 8'd3);
            check("mh_stay0", int'({s1, s0}), 0);
        end
        step(0, 4'h1, 8'd3);

        // Stop mid-hold on ch2, then en with empty mask.
        for (int i = 0; i < 10; i++) step(1, 4'hF, 8'd3);
        check("stop_on_ch2", int'({s1, s0}), 2);
        step(0, 4'hF, 8'd3);
        check("stop_valid", int'(valid), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'h0, 8'd3);
            check("empty_valid", int'(valid), 0);
        end

        // Long dwell: ch_start spacing of 256 cycles.
        last_cs = -1;
        for (int i = 0; i < 600; i++) begin
            step(1, 4'h1, 8'hFF);
            if (ch_start) begin
                if (last_cs >= 0) check("long_spacing", i - last_cs, 256);
                last_cs = i;
            end
        end
        check("long_seen", int'(last_cs >= 256), 1);
        step(0, 4'h1, 8'hFF);

        // Randomized stimulus against the model.
        rm = 4'hF;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) rm = 4'($urandom_range(0, 15));
            step($urandom_range(0, 19) != 0, rm, 8'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) async_reset();
            cyc++;
        end
        check("rand_ran", cyc, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
